// File: rtl/lane_pkg.sv
// Shared types and default sizing for the lane packer.
// Exports pack_state_t, lane_t and the WIDTH/LANES/CNT_W defaults.
package lane_pkg;

    localparam int WIDTH = 10;
    localparam int LANES = 48;
    localparam int CNT_W = $clog2(LANES + 1);

    typedef enum logic {
        FILL,
        FULL
    } pack_state_t;

    typedef logic [WIDTH-1:0] lane_t;

endpackage

// File: rtl/lane_ptr.sv
// Lane write pointer: increments per accepted word, clears on frame end or flush.
// Ports: clk, rst, inc_i, clr_i -> ptr_o (current lane), tc_o (at last lane).
module lane_ptr
    import lane_pkg::*;
#(
    parameter int LANES_P = LANES,
    parameter int CNT_WP  = $clog2(LANES_P + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [CNT_WP-1:0] ptr_o,
    output logic              tc_o
);

    logic [CNT_WP-1:0] ptr_q;
    logic [CNT_WP-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + CNT_WP'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
    assign tc_o  = (ptr_q == CNT_WP'(LANES_P - 1));

endmodule

// File: rtl/lane_packer.sv
// Packs WIDTH-bit words into consecutive lanes of a LANES*WIDTH frame.
// Ports: in_* word handshake, out_* frame handshake, clr sync flush, rst async.
module lane_packer
    import lane_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    parameter int LANES_P = LANES,
    parameter int CNT_WP  = $clog2(LANES_P + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [WIDTH_P-1:0]         in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [LANES_P*WIDTH_P-1:0] out_data,
    output logic [LANES_P-1:0]         out_mask,
    output logic [CNT_WP-1:0]          out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);

    pack_state_t state_q;
    pack_state_t state_d;

    logic [LANES_P*WIDTH_P-1:0] data_q;
    logic [LANES_P-1:0]         mask_q;
    logic [CNT_WP-1:0]          count_q;
    logic [CNT_WP-1:0]          ptr;
    logic                       tc;
    logic                       accept;
    logic                       done;
    logic                       drain;

    // accept is zero whenever in_valid is low, so X on in_last cannot leak.
    assign accept = (state_q == FILL) && in_valid && !clr;
    assign done   = accept && (tc || in_last);
    assign drain  = (state_q == FULL) && out_ready && !clr;

    lane_ptr #(
        .LANES_P(LANES_P),
        .CNT_WP (CNT_WP)
    ) u_ptr (
        .clk  (clk),
        .rst  (rst),
        .inc_i(accept && !done),
        .clr_i(clr || done),
        .ptr_o(ptr),
        .tc_o (tc)
    );

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = FILL;
        end else begin
            unique case (state_q)
                FILL:    if (done) state_d = FULL;
                FULL:    if (out_ready) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
        end else if (clr || drain) begin
            data_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
        end else if (accept) begin
            data_q[int'(ptr)*WIDTH_P +: WIDTH_P] <= in_data;
            mask_q[ptr]                          <= 1'b1;
            count_q                              <= ptr + CNT_WP'(1);
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_mask  = mask_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_lane_packer.sv
// Randomized self-checking bench for lane_packer against a queue-based frame model.
// Each task drives one scenario and compares outputs inline.
module tb_lane_packer;
    import lane_pkg::*;

    localparam int FW = LANES * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [FW-1:0]    out_data;
    logic [LANES-1:0] out_mask;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;

    int tests = 0;
    int fails = 0;

    lane_packer dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_mask (out_mask),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] words[$];

    // Model: word k of the frame sits in lane k; all other lanes are zero.
    function automatic void build(input logic [WIDTH-1:0] w[$],
                                  output logic [FW-1:0] d,
                                  output logic [LANES-1:0] m,
                                  output logic [CNT_W-1:0] c);
        d = '0;
        m = '0;
        foreach (w[k]) begin
            d[k*WIDTH +: WIDTH] = w[k];
            m[k] = 1'b1;
        end
        c = CNT_W'(w.size());
    endfunction

    function automatic logic [WIDTH-1:0] or_lanes(input logic [FW-1:0] d);
        logic [WIDTH-1:0] r = '0;
        for (int k = 0; k < LANES; k++) r |= d[k*WIDTH +: WIDTH];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 'x;
    endtask

    // Drive one word for one edge; it is accepted because the packer is in FILL.
    task automatic push(input logic [WIDTH-1:0] w, input logic last);
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        words.push_back(w);
        step();
        idle_inputs();
    endtask

    task automatic check_frame(input string name);
        logic [FW-1:0]    ed;
        logic [LANES-1:0] em;
        logic [CNT_W-1:0] ec;
        build(words, ed, em, ec);
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s valid/ready: got %b/%b want 1/0", name, out_valid, in_ready);
        end
        tests++;
        if (out_data !== ed) begin
            fails++;
            $display("FAIL %s data: got %h want %h", name, out_data, ed);
        end
        tests++;
        if (out_mask !== em || out_count !== ec) begin
            fails++;
            $display("FAIL %s mask/count: got %h/%0d want %h/%0d", name, out_mask, out_count, em, ec);
        end
    endtask

    task automatic check_empty(input string name);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 ||
            out_mask !== '0 || out_count !== '0) begin
            fails++;
            $display("FAIL %s empty: valid=%b ready=%b mask=%h count=%0d", name, out_valid, in_ready, out_mask, out_count);
        end
    endtask

    task automatic drain_frame();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        words.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        #12;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_mask !== '0 || out_count !== '0) begin
            fails++;
            $display("FAIL reset outputs: valid=%b mask=%h count=%0d", out_valid, out_mask, out_count);
        end
        rst = 1'b0;
        step();
        check_empty("reset_release");
    endtask

    task automatic test_full_frame();
        words.delete();
        for (int k = 0; k < LANES; k++) begin
            if (k == LANES - 1) begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL full_early valid: got %b want 0", out_valid);
                end
            end
            push(WIDTH'(k), 1'b0);
        end
        check_frame("full_frame");
        drain_frame();
        check_empty("full_drain");
    endtask

    task automatic test_early_last();
        words.delete();
        push(10'h3FF, 1'b0);
        push(10'h001, 1'b0);
        push(10'h155, 1'b1);
        check_frame("early_last");
        tests++;
        if (out_mask !== 48'h7 || out_count !== 3) begin
            fails++;
            $display("FAIL early_mask: got %h/%0d want 7/3", out_mask, out_count);
        end
        drain_frame();
        check_empty("early_drain");
    endtask

    task automatic test_last_on_final_lane();
        words.delete();
        for (int k = 0; k < LANES; k++) push(WIDTH'($urandom), k == LANES - 1);
        check_frame("last_final");
        drain_frame();
        step();
        step();
        check_empty("last_final_single");
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] held;
        words.delete();
        for (int k = 0; k < LANES; k++) push(WIDTH'($urandom), 1'b0);
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            in_last  = 1'($urandom);
            step();
            tests++;
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL backpressure cyc%0d: ready=%b valid=%b", c, in_ready, out_valid);
            end
        end
        idle_inputs();
        check_frame("bp_frame");
        drain_frame();
        step();
        step();
        check_empty("bp_single");
        // A flush also discards a held frame.
        words.delete();
        push(10'h2AA, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_empty("clr_full");
    endtask

    task automatic test_clr();
        words.delete();
        for (int k = 0; k < 10; k++) push(WIDTH'($urandom), 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 10'h3C3;
        in_last  = 1'b1;
        step();
        clr = 1'b0;
        idle_inputs();
        check_empty("clr_partial");
        words.delete();
        for (int k = 0; k < LANES; k++) push(WIDTH'($urandom), 1'b0);
        check_frame("clr_next");
        drain_frame();
    endtask

    task automatic test_async_rst();
        words.delete();
        for (int k = 0; k < 20; k++) push(WIDTH'($urandom), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out_mask !== '0 || out_count !== '0 || out_data !== '0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: mask=%h count=%0d", out_mask, out_count);
        end
        #2;
        rst = 1'b0;
        step();
        words.delete();
        for (int k = 0; k < 5; k++) push(WIDTH'($urandom), k == 4);
        check_frame("async_restart");
        drain_frame();
    endtask

    task automatic test_random_roundtrip();
        for (int f = 0; f < 25; f++) begin
            int n;
            logic [WIDTH-1:0] acc;
            int waited;
            n   = $urandom_range(1, LANES);
            acc = '0;
            words.delete();
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) step();
                push(WIDTH'($urandom), k == n - 1);
                acc |= words[k];
            end
            waited = 0;
            while (out_valid !== 1'b1 && waited < 4) begin
                step();
                waited++;
            end
            check_frame($sformatf("rand%0d", f));
            tests++;
            if (or_lanes(out_data) !== acc) begin
                fails++;
                $display("FAIL rand%0d reduce: got %h want %h", f, or_lanes(out_data), acc);
            end
            repeat ($urandom_range(0, 3)) step();
            drain_frame();
            check_empty($sformatf("rand%0d_drain", f));
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_early_last();
        test_last_on_final_lane();
        test_backpressure();
        test_clr();
        test_async_rst();
        test_random_roundtrip();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
